sample_collector: RTL

Bus-mastering scanner that sits directly downstream of the per-pin controllers. It round-robin polls each controller's sample counter and sample register over the shared pin-controller address bus. Each new sample is packed into a 16-bit record and pushed into an internal show-ahead FIFO that the host interface drains. This replaces host-side polling of individual pins for input streaming.

---
 rtl/sample_collector.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sample_collector.sv
`default_nettype none
// ============================================================================
// Module      : sample_collector
// Description : Round-robin scanner of the per-pin controllers. Each pin's
//               SAMPLE_CNT is read over the shared pin-controller bus. When it
//               differs from the last value seen, SAMPLE_REG is read too. The
//               resulting 16-bit record is pushed into a show-ahead FIFO that
//               the host drains.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   1   system clock
//   reset       in   1   asynchronous reset, active low
//   enable      in   1   scan enable (level)
//   pc_enable   out  1   pin-controller bus enable
//   pc_addr     out  19  {POSITION[10:0], register byte address[7:0]}
//   pc_data_rd  out  1   bus read strobe
//   pc_data_in  in   16  OR of controller read data (one cycle latency)
//   fifo_rd     in   1   pop strobe
//   fifo_data   out  16  head record {sample, pin[6:0], cnt[7:0]}
//   fifo_empty  out  1   FIFO empty
//   fifo_count  out  9   records held
//   overflow    out  1   sticky: record dropped on a full FIFO
//   lost        out  1   sticky: a counter advanced by more than one
//   clr_flags   in   1   clears overflow and lost
// ============================================================================
module sample_collector #(
  parameter int NUM_PINS       = 8,
  parameter int FIRST_POSITION = 0,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        pc_enable,
  output logic [18:0] pc_addr,
  output logic        pc_data_rd,
  input  logic [15:0] pc_data_in,
  input  logic        fifo_rd,
  output logic [15:0] fifo_data,
  output logic        fifo_empty,
  output logic [8:0]  fifo_count,
  output logic        overflow,
  output logic        lost,
  input  logic        clr_flags
);

  localparam int         IW           = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam int         PW           = $clog2(FIFO_DEPTH);
  localparam logic [7:0] c_SAMPLE_REG = 8'd7;
  localparam logic [7:0] c_SAMPLE_CNT = 8'd8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CNT  = 3'd1,
    S_CAP_CNT = 3'd2,
    S_RD_REG  = 3'd3,
    S_CAP_REG = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_next;
  logic [15:0]     r_cnt;
  logic [15:0]     r_last_cnt [NUM_PINS];
  logic [15:0]     w_last;
  logic [15:0]     w_delta;
  logic            w_changed;
  logic            w_slot_done;
  logic            w_push;
  logic            w_lost_set;
  logic [15:0]     w_record;
  logic [10:0]     w_pos;

  // FIFO storage
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [8:0]      r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_wr;
  logic            r_overflow;
  logic            r_lost;

  assign w_last     = r_last_cnt[r_idx];
  assign w_delta    = pc_data_in - w_last;
  assign w_changed  = (pc_data_in != w_last);
  assign w_idx_next = (r_idx == IW'(NUM_PINS - 1)) ? '0 : r_idx + 1'b1;
  assign w_pos      = 11'(FIRST_POSITION) + 11'(r_idx);
  assign w_record   = {pc_data_in[0], 7'(r_idx), r_cnt[7:0]};

  // --------------------------------------------------------------------------
  // Next-state and bus outputs. Bus outputs decode directly from the state
  // register so an asynchronous reset drops them without waiting for a clock.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    pc_enable    = 1'b0;
    pc_data_rd   = 1'b0;
    pc_addr      = '0;
    w_push       = 1'b0;
    w_lost_set   = 1'b0;
    w_slot_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next_state = S_RD_CNT;
      end
      S_RD_CNT: begin
        pc_enable    = 1'b1;
        pc_data_rd   = 1'b1;
        pc_addr      = {w_pos, c_SAMPLE_CNT};
        w_next_state = S_CAP_CNT;
      end
      S_CAP_CNT: begin
        if (w_changed) begin
          // Wrap 0xFFFF->0x0000 is a delta of 1 thanks to modular subtraction.
          w_lost_set   = (w_delta > 16'd1);
          w_next_state = S_RD_REG;
        end else begin
          w_slot_done  = 1'b1;
          w_next_state = enable ? S_RD_CNT : S_IDLE;
        end
      end
      S_RD_REG: begin
        pc_enable    = 1'b1;
        pc_data_rd   = 1'b1;
        pc_addr      = {w_pos, c_SAMPLE_REG};
        w_next_state = S_CAP_REG;
      end
      S_CAP_REG: begin
        w_push       = 1'b1;
        w_slot_done  = 1'b1;
        w_next_state = enable ? S_RD_CNT : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < NUM_PINS; i++) r_last_cnt[i] <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE) r_idx <= '0;
      if (r_state == S_CAP_CNT) r_cnt <= pc_data_in;
      if (r_state == S_CAP_REG) r_last_cnt[r_idx] <= r_cnt;
      if (w_slot_done) r_idx <= enable ? w_idx_next : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO. A push into a full FIFO succeeds only if a pop frees a
  // slot in the same cycle; otherwise the record is dropped.
  // --------------------------------------------------------------------------
  assign w_full  = (r_count == 9'(FIFO_DEPTH));
  assign w_empty = (r_count == 9'd0);
  assign w_pop   = fifo_rd & ~w_empty;
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_record;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 9'd1;
        2'b01:   r_count <= r_count - 9'd1;
        default: r_count <= r_count;
      endcase
      // Clear wins over a same-cycle set.
      if (clr_flags) begin
        r_overflow <= 1'b0;
        r_lost     <= 1'b0;
      end else begin
        if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
        if (w_lost_set)               r_lost     <= 1'b1;
      end
    end
  end

  assign fifo_data  = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
  assign fifo_empty = w_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign lost       = r_lost;

endmodule
`default_nettype wire
